// File: rtl/serial_receiver.sv
// serial_receiver: reassembles DATA_W-bit chunks (LSB chunk first) from the
// serial transceiver into one WORD_W-bit operand word. The word is offered
// through a valid/ack handshake, and sticky framing/overrun flags are kept.
module serial_receiver #(
    parameter int DATA_W = 5,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              dinValid,
    input  logic              dinLast,
    input  logic              doutAck,
    input  logic              clrErr,
    output logic [WORD_W-1:0] dout,
    output logic              doutValid,
    output logic              rxBusy,
    output logic              frameErr,
    output logic              overrun
);

    localparam int NCHUNK = (WORD_W + DATA_W - 1) / DATA_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DRAIN
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [WORD_W-1:0]   shreg;

    logic [IDX_W-1:0]    cur_idx;
    logic [WORD_W-1:0]   merged;
    logic                accept;
    logic                at_last;
    logic                complete;
    logic                short_err;
    logic                long_err;
    logic                can_load;

    // Place the incoming chunk into its slice of the partial word; IDLE always
    // starts a fresh word at chunk 0, and bits past WORD_W are dropped.
    always_comb begin
        cur_idx = (state == IDLE) ? '0 : idx;
        merged  = (state == IDLE) ? '0 : shreg;
        for (int b = 0; b < WORD_W; b++) begin
            if (int'(cur_idx) == (b / DATA_W)) begin
                merged[b] = din[b % DATA_W];
            end
        end
    end

    // Classify this cycle's chunk: frame complete, short frame or long frame.
    always_comb begin
        accept    = dinValid && (state != DRAIN);
        at_last   = (cur_idx == LAST_IDX);
        complete  = accept && at_last && dinLast;
        short_err = accept && !at_last && dinLast;
        long_err  = accept && at_last && !dinLast;
        can_load  = !doutValid || doutAck;
    end

    assign rxBusy = (state != IDLE);

    // Frame state machine with the output word, handshake and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            shreg     <= '0;
            dout      <= '0;
            doutValid <= 1'b0;
            frameErr  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (doutValid && doutAck) begin
                doutValid <= 1'b0;
            end
            if (complete && can_load) begin
                dout      <= merged;
                doutValid <= 1'b1;
            end

            if (clrErr) begin
                frameErr <= 1'b0;
                overrun  <= 1'b0;
            end
            if (short_err || long_err) begin
                frameErr <= 1'b1;
            end
            if (complete && !can_load) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE, RECV: begin
                    if (dinValid) begin
                        if (complete || short_err) begin
                            state <= IDLE;
                            idx   <= '0;
                            shreg <= '0;
                        end else if (long_err) begin
                            state <= DRAIN;
                            idx   <= '0;
                            shreg <= '0;
                        end else begin
                            state <= RECV;
                            idx   <= cur_idx + IDX_W'(1);
                            shreg <= merged;
                        end
                    end
                end
                DRAIN: begin
                    if (dinValid && dinLast) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- Receive-side stage directly downstream of the calculator's serial transceiver.
- Collects DATA_W-bit chunks, LSB chunk first, and reassembles them into one WORD_W-bit operand word.
- Presents the word with a valid/ack handshake to the operand register and flags framing and overrun errors.
- Single clock domain; the transceiver output is already synchronised to clk.

Parameters:
- DATA_W, 5: chunk width in bits.
- WORD_W, 32: reassembled word width. NCHUNK = ceil(WORD_W/DATA_W), which is 7 at defaults.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- din  input  DATA_W  chunk data, sampled when dinValid=1.
- dinValid  input  1  chunk strobe, one chunk per cycle when high.
- dinLast  input  1  qualifies the final chunk of a frame; ignored when dinValid=0.
- doutAck  input  1  consumer accepts dout; only meaningful while doutValid=1.
- clrErr  input  1  synchronous clear of frameErr and overrun.
- dout  output  WORD_W  last completed word, held stable while doutValid=1.
- doutValid  output  1  level; set on frame completion, cleared by ack.
- rxBusy  output  1  high in RECV or DRAIN.
- frameErr  output  1  sticky framing error.
- overrun  output  1  sticky; a completed frame was dropped.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, chunk index=0, shift register=0.
  - dout=0, doutValid=0, rxBusy=0, frameErr=0, overrun=0.
- Chunk placement:
  - Chunk k (k = 0..NCHUNK-1) is written to bits [k*DATA_W +: DATA_W], truncated at WORD_W.
  - At defaults, chunk 6 contributes only din[1:0]; din[4:2] is ignored.
- States:
  - IDLE: dinValid=1 stores chunk 0.
    - With dinLast=1 and NCHUNK>1: frameErr=1, stay in IDLE.
    - Otherwise: index=1, go to RECV.
  - RECV: each dinValid stores chunk[index].
    - index<NCHUNK-1 and dinLast=1: short frame. frameErr=1, discard partial word, go to IDLE.
    - index<NCHUNK-1 and dinLast=0: index++.
    - index==NCHUNK-1 and dinLast=1: frame complete, index=0, go to IDLE.
    - index==NCHUNK-1 and dinLast=0: long frame. frameErr=1, discard, go to DRAIN.
  - DRAIN: ignore chunks until dinValid&dinLast, then go to IDLE. No word is produced.
- Completion:
  - dout and doutValid update on the edge that samples the last chunk, so they are visible the next cycle.
  - Latency: 1 cycle after the final chunk.
  - Gaps (dinValid=0) are allowed anywhere inside a frame; there is no timeout.
- Handshake:
  - doutAck=1 while doutValid=1 clears doutValid on the next edge.
  - doutAck while doutValid=0 has no effect.
- Simultaneous events:
  - Completion with doutValid=1 and doutAck=1 in the same cycle: new word loads, doutValid stays 1, no overrun.
  - Completion with doutValid=1 and doutAck=0: new word dropped, dout unchanged, overrun=1.
- Errors:
  - Sticky until clrErr=1.
  - clrErr coinciding with a new error event: the error wins and the flag stays 1.
  - Errors never block reception of later frames.
- Reset mid-frame: partial word lost, outputs return to reset values immediately (asynchronously).
- Dimensions: rxBusy is combinational from state. The chunk index needs ceil(log2(NCHUNK)) bits.

Test Plan:
- Nominal frame: 0xF10F10F1 sent as chunks 0x11,0x07,0x04,0x1E,0x10,0x18,0x03, dinLast on the 7th. Required: dout=32'hF10F10F1 and doutValid=1 one cycle later; rxBusy=1 from cycle 2 to 7; no errors.
- Gapped frame: same chunks with dinValid=0 cycles between each. Required: identical dout. Then assert doutAck: doutValid=0 next cycle.
- Short frame: 3 chunks with dinLast on the 3rd. Required: frameErr=1, doutValid stays 0, state IDLE. A following nominal frame with 0x00000000 chunks still yields dout=0 with doutValid=1.
- Long frame: 8 chunks, dinLast on the 8th. Required: frameErr=1 at chunk 7, no word produced, rxBusy drops after chunk 8. clrErr then clears frameErr.
- Overrun: two nominal frames (0xF10F10F1, then 0x0000001F via chunks 0x1F,0,0,0,0,0,0) with no ack. Required: dout stays 0xF10F10F1 and overrun=1. Repeat with doutAck held in the completion cycle: dout=0x0000001F, overrun=0.
- Async reset asserted after chunk 4 of a frame. Required: all outputs are 0 immediately. After release, a full frame reassembles correctly.
